// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: parametrised keypad combination-lock controller.
// Takes scanner key levels, edge-detects them, buffers a code entry and
// runs the lock / open / code-change / lockout state machine. Adds attempt
// counting, a timed lockout, auto-relock, an idle entry timeout and a
// two-step verified code change with ok/err pulses.
module keypad_lock_ctrl #(
  parameter int DIGITS      = 4,
  parameter int KEY_W       = 4,
  parameter logic [DIGITS*KEY_W-1:0] DEFAULT_CODE = 16'h2342,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int OPEN_CYC    = 500,
  parameter int IDLE_CYC    = 2000
) (
  input  logic                          clk,
  input  logic                          reset_1,
  input  logic [KEY_W-1:0]              Code_1,
  input  logic                          Valid_1,
  input  logic                          set,
  output logic                          OPEN,
  output logic                          LOCK,
  output logic                          SET,
  output logic                          CHANGE,
  output logic                          LOCKOUT,
  output logic                          ok_pulse,
  output logic                          err_pulse,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
  output logic [DIGITS*KEY_W-1:0]       data_1
);

  localparam int CW     = DIGITS * KEY_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FAIL_W = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
  localparam int OPEN_W = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
  localparam int IDLE_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int LO_W   = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  // Terminal counts: each timer counts 0..N-1, so the event it guards
  // becomes visible exactly N cycles after the timer was last restarted.
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [OPEN_W-1:0] OPEN_LAST = OPEN_W'(OPEN_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
  localparam logic [LO_W-1:0]   LO_LAST   = LO_W'(LOCKOUT_CYC - 1);

  localparam logic [KEY_W-1:0] KEY_NINE  = KEY_W'(9);
  localparam logic [KEY_W-1:0] KEY_STAR  = KEY_W'(10);
  localparam logic [KEY_W-1:0] KEY_ENTER = KEY_W'(11);

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_OPEN    = 3'd1,
    S_NEW1    = 3'd2,
    S_NEW2    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic              valid_q, set_q;
  logic [CW-1:0]     code_reg, code_next;
  logic [CW-1:0]     cand_reg, cand_next;
  logic [CW-1:0]     buf_reg, buf_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ovr_reg, ovr_next;
  logic [FAIL_W-1:0] fail_reg, fail_next;
  logic [OPEN_W-1:0] open_tmr_reg, open_tmr_next;
  logic [IDLE_W-1:0] idle_tmr_reg, idle_tmr_next;
  logic [LO_W-1:0]   lo_tmr_reg, lo_tmr_next;
  logic              ok_reg, ok_next;
  logic              err_reg, err_next;

  logic              key_evt, set_evt;
  logic              is_digit, is_star, is_enter;
  logic              full, complete, code_match, cand_match;
  logic              entry_state, idle_run, idle_done;
  logic [FAIL_W-1:0] fail_inc;
  logic              clear;

  // Rising-edge detection of the scanner valid level and the set request.
  assign key_evt = Valid_1 & ~valid_q;
  assign set_evt = set & ~set_q;

  assign is_digit = (Code_1 <= KEY_NINE);
  assign is_star  = (Code_1 == KEY_STAR);
  assign is_enter = (Code_1 == KEY_ENTER);

  // An overrun entry is never complete, so it can never match.
  assign full       = (cnt_reg == CNT_FULL);
  assign complete   = full & ~ovr_reg;
  assign code_match = complete && (buf_reg == code_reg);
  assign cand_match = complete && (buf_reg == cand_reg);

  assign fail_inc = (fail_reg == FAIL_MAX) ? fail_reg : fail_reg + FAIL_W'(1);

  // The idle timer only matters while there is something to discard.
  assign entry_state = (state_reg == S_LOCKED) || (state_reg == S_NEW1) ||
                       (state_reg == S_NEW2);
  assign idle_run    = ((state_reg == S_LOCKED) && (cnt_reg != '0)) ||
                       (state_reg == S_NEW1) || (state_reg == S_NEW2);
  assign idle_done   = idle_run && !key_evt && (idle_tmr_reg == IDLE_LAST);

  // Next-state, datapath and pulse decisions for one clock.
  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    cand_next     = cand_reg;
    buf_next      = buf_reg;
    cnt_next      = cnt_reg;
    ovr_next      = ovr_reg;
    fail_next     = fail_reg;
    ok_next       = 1'b0;
    err_next      = 1'b0;
    open_tmr_next = '0;
    idle_tmr_next = '0;
    lo_tmr_next   = '0;
    clear         = 1'b0;

    if (idle_run && !key_evt && !idle_done) begin
      idle_tmr_next = idle_tmr_reg + IDLE_W'(1);
    end

    // Digit entry is common to every state that collects a code.
    if (entry_state && key_evt && is_digit) begin
      if (!full) begin
        buf_next[int'(cnt_reg)*KEY_W +: KEY_W] = Code_1;
        cnt_next = cnt_reg + CNT_W'(1);
      end else begin
        ovr_next = 1'b1;
      end
    end

    case (state_reg)
      S_LOCKED: begin
        if (key_evt) begin
          if (is_star && !full) begin
            clear = 1'b1;
          end else if (is_enter || is_star) begin
            // '#' or a '*' on a full buffer terminates the attempt.
            clear = 1'b1;
            if (code_match) begin
              ok_next = 1'b1;
              if (is_enter) begin
                state_next = S_OPEN;
                fail_next  = '0;
              end else begin
                state_next = S_NEW1;
              end
            end else begin
              err_next  = 1'b1;
              fail_next = fail_inc;
              if (fail_inc == FAIL_MAX) begin
                state_next = S_LOCKOUT;
              end
            end
          end
        end else if (idle_done) begin
          clear = 1'b1;
        end
      end

      S_OPEN: begin
        if (set_evt) begin
          // A change request beats any key landing in the same cycle.
          state_next = S_NEW1;
          clear      = 1'b1;
        end else if (key_evt) begin
          if (is_enter) begin
            state_next = S_LOCKED;
          end
        end else if (open_tmr_reg == OPEN_LAST) begin
          state_next = S_LOCKED;
        end else begin
          open_tmr_next = open_tmr_reg + OPEN_W'(1);
        end
      end

      S_NEW1: begin
        if (key_evt) begin
          if (is_star) begin
            clear = 1'b1;
          end else if (is_enter) begin
            clear = 1'b1;
            if (complete) begin
              cand_next  = buf_reg;
              state_next = S_NEW2;
            end else begin
              err_next = 1'b1;
            end
          end
        end else if (idle_done) begin
          clear      = 1'b1;
          err_next   = 1'b1;
          state_next = S_LOCKED;
        end
      end

      S_NEW2: begin
        if (key_evt) begin
          if (is_star) begin
            clear = 1'b1;
          end else if (is_enter) begin
            clear      = 1'b1;
            state_next = S_LOCKED;
            if (cand_match) begin
              code_next = cand_reg;
              ok_next   = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end else if (idle_done) begin
          clear      = 1'b1;
          err_next   = 1'b1;
          state_next = S_LOCKED;
        end
      end

      S_LOCKOUT: begin
        clear = 1'b1;
        if (lo_tmr_reg == LO_LAST) begin
          state_next = S_LOCKED;
          fail_next  = '0;
        end else begin
          lo_tmr_next = lo_tmr_reg + LO_W'(1);
        end
      end

      default: begin
        state_next = S_LOCKED;
        clear      = 1'b1;
      end
    endcase

    if (clear) begin
      buf_next = '0;
      cnt_next = '0;
      ovr_next = 1'b0;
    end
  end

  // State and datapath registers; reset restores the default code.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      state_reg    <= S_LOCKED;
      valid_q      <= 1'b0;
      set_q        <= 1'b0;
      code_reg     <= DEFAULT_CODE;
      cand_reg     <= '0;
      buf_reg      <= '0;
      cnt_reg      <= '0;
      ovr_reg      <= 1'b0;
      fail_reg     <= '0;
      open_tmr_reg <= '0;
      idle_tmr_reg <= '0;
      lo_tmr_reg   <= '0;
      ok_reg       <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      valid_q      <= Valid_1;
      set_q        <= set;
      code_reg     <= code_next;
      cand_reg     <= cand_next;
      buf_reg      <= buf_next;
      cnt_reg      <= cnt_next;
      ovr_reg      <= ovr_next;
      fail_reg     <= fail_next;
      open_tmr_reg <= open_tmr_next;
      idle_tmr_reg <= idle_tmr_next;
      lo_tmr_reg   <= lo_tmr_next;
      ok_reg       <= ok_next;
      err_reg      <= err_next;
    end
  end

  assign OPEN      = (state_reg == S_OPEN);
  assign LOCK      = (state_reg != S_OPEN);
  assign SET       = (state_reg == S_NEW1);
  assign CHANGE    = (state_reg == S_NEW2);
  assign LOCKOUT   = (state_reg == S_LOCKOUT);
  assign ok_pulse  = ok_reg;
  assign err_pulse = err_reg;
  assign digit_cnt = cnt_reg;
  assign data_1    = buf_reg;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Testbench for keypad_lock_ctrl: a table of key presses / idle waits with
// expected outputs, followed by hand-written multi-cycle corner cases.
module tb_keypad_lock_ctrl;

  logic        clk = 1'b0;
  logic        reset_1;
  logic [3:0]  Code_1;
  logic        Valid_1;
  logic        set;
  logic        OPEN, LOCK, SET, CHANGE, LOCKOUT, ok_pulse, err_pulse;
  logic [2:0]  digit_cnt;
  logic [15:0] data_1;

  keypad_lock_ctrl dut (
    .clk       (clk),
    .reset_1   (reset_1),
    .Code_1    (Code_1),
    .Valid_1   (Valid_1),
    .set       (set),
    .OPEN      (OPEN),
    .LOCK      (LOCK),
    .SET       (SET),
    .CHANGE    (CHANGE),
    .LOCKOUT   (LOCKOUT),
    .ok_pulse  (ok_pulse),
    .err_pulse (err_pulse),
    .digit_cnt (digit_cnt),
    .data_1    (data_1)
  );

  always #5 clk = ~clk;

  // Flag order: OPEN LOCK SET CHANGE LOCKOUT ok err
  localparam logic [6:0] F_LOCKED  = 7'b0100000;
  localparam logic [6:0] F_ERR     = 7'b0100001;
  localparam logic [6:0] F_OK_LOCK = 7'b0100010;
  localparam logic [6:0] F_OPEN    = 7'b1000000;
  localparam logic [6:0] F_OPEN_OK = 7'b1000010;
  localparam logic [6:0] F_SET     = 7'b0110000;
  localparam logic [6:0] F_SET_OK  = 7'b0110010;
  localparam logic [6:0] F_CHANGE  = 7'b0101000;
  localparam logic [6:0] F_LO      = 7'b0100100;
  localparam logic [6:0] F_LO_ERR  = 7'b0100101;

  localparam logic [3:0] K_STAR  = 4'hA;
  localparam logic [3:0] K_ENTER = 4'hB;

  typedef struct {
    logic        press;
    int          wait_cyc;
    logic [3:0]  key;
    logic [6:0]  flags;
    logic [2:0]  cnt;
    logic [15:0] data;
  } row_t;

  row_t rows[$];
  int checks = 0;
  int passes = 0;

  function automatic logic [25:0] snap();
    return {OPEN, LOCK, SET, CHANGE, LOCKOUT, ok_pulse, err_pulse, digit_cnt, data_1};
  endfunction

  task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
      $display("ok   %s flags=%b cnt=%0d data=%h", name, got[25:19], got[18:16], got[15:0]);
    end else begin
      $display("FAIL %s got flags=%b cnt=%0d data=%h required flags=%b cnt=%0d data=%h",
               name, got[25:19], got[18:16], got[15:0], exp[25:19], exp[18:16], exp[15:0]);
    end
  endtask

  task automatic add(input logic press, input int w, input logic [3:0] key,
                     input logic [6:0] fl, input logic [2:0] cnt, input logic [15:0] data);
    row_t r;
    r.press = press; r.wait_cyc = w; r.key = key;
    r.flags = fl; r.cnt = cnt; r.data = data;
    rows.push_back(r);
  endtask

  // Four digit presses; code holds the first-entered digit in bits [3:0].
  task automatic add_digits(input logic [15:0] code, input logic [6:0] fl);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] mask;
      mask = (32'h1 << (4 * (i + 1))) - 32'h1;
      add(1'b1, 0, code[i*4 +: 4], fl, 3'(i + 1), code & mask[15:0]);
    end
  endtask

  task automatic press(input logic [3:0] k);
    Code_1  = k;
    Valid_1 = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_key();
    Valid_1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic tap(input logic [3:0] k);
    press(k);
    release_key();
  endtask

  task automatic press_check(input string name, input logic [3:0] k, input logic [6:0] fl,
                             input logic [2:0] cnt, input logic [15:0] data);
    press(k);
    check(name, snap(), {fl, cnt, data});
    release_key();
  endtask

  initial begin
    reset_1 = 1'b0;
    Valid_1 = 1'b0;
    set     = 1'b0;
    Code_1  = 4'h0;
    repeat (3) @(negedge clk);
    check("reset", snap(), {F_LOCKED, 3'd0, 16'h0000});
    reset_1 = 1'b1;
    @(negedge clk);

    // Open with default code, '*' clear on partial entry, auto-relock.
    add(1'b1, 0, 4'h7, F_LOCKED, 3'd1, 16'h0007);
    add(1'b1, 0, K_STAR, F_LOCKED, 3'd0, 16'h0000);
    add_digits(16'h2342, F_LOCKED);
    add(1'b1, 0, K_ENTER, F_OPEN_OK, 3'd0, 16'h0000);
    add(1'b0, 0, 4'h0, F_OPEN, 3'd0, 16'h0000);
    add(1'b0, 498, 4'h0, F_OPEN, 3'd0, 16'h0000);
    add(1'b0, 1, 4'h0, F_LOCKED, 3'd0, 16'h0000);
    // Three wrong attempts -> lockout; keys ignored; timed release.
    for (int a = 0; a < 3; a++) begin
      add_digits(16'h1111, F_LOCKED);
      add(1'b1, 0, K_ENTER, (a == 2) ? F_LO_ERR : F_ERR, 3'd0, 16'h0000);
    end
    add(1'b1, 0, 4'h2, F_LO, 3'd0, 16'h0000);
    add(1'b1, 0, 4'h4, F_LO, 3'd0, 16'h0000);
    add(1'b1, 0, 4'h3, F_LO, 3'd0, 16'h0000);
    add(1'b1, 0, 4'h2, F_LO, 3'd0, 16'h0000);
    add(1'b1, 0, K_ENTER, F_LO, 3'd0, 16'h0000);
    add(1'b0, 988, 4'h0, F_LO, 3'd0, 16'h0000);
    add(1'b0, 1, 4'h0, F_LOCKED, 3'd0, 16'h0000);
    add_digits(16'h2342, F_LOCKED);
    add(1'b1, 0, K_ENTER, F_OPEN_OK, 3'd0, 16'h0000);
    add(1'b1, 0, K_ENTER, F_LOCKED, 3'd0, 16'h0000);
    // Idle timeout discards a partial entry without a pulse.
    add(1'b1, 0, 4'h9, F_LOCKED, 3'd1, 16'h0009);
    add(1'b0, 1998, 4'h0, F_LOCKED, 3'd1, 16'h0009);
    add(1'b0, 1, 4'h0, F_LOCKED, 3'd0, 16'h0000);
    // Change with mismatching confirmation: code unchanged.
    add_digits(16'h2342, F_LOCKED);
    add(1'b1, 0, K_STAR, F_SET_OK, 3'd0, 16'h0000);
    add_digits(16'h8765, F_SET);
    add(1'b1, 0, K_ENTER, F_CHANGE, 3'd0, 16'h0000);
    add_digits(16'h9765, F_CHANGE);
    add(1'b1, 0, K_ENTER, F_ERR, 3'd0, 16'h0000);
    add_digits(16'h2342, F_LOCKED);
    add(1'b1, 0, K_ENTER, F_OPEN_OK, 3'd0, 16'h0000);
    add(1'b1, 0, K_ENTER, F_LOCKED, 3'd0, 16'h0000);
    // Successful change to 5,6,7,8; old code then rejected.
    add_digits(16'h2342, F_LOCKED);
    add(1'b1, 0, K_STAR, F_SET_OK, 3'd0, 16'h0000);
    add_digits(16'h8765, F_SET);
    add(1'b1, 0, K_ENTER, F_CHANGE, 3'd0, 16'h0000);
    add_digits(16'h8765, F_CHANGE);
    add(1'b1, 0, K_ENTER, F_OK_LOCK, 3'd0, 16'h0000);
    add_digits(16'h2342, F_LOCKED);
    add(1'b1, 0, K_ENTER, F_ERR, 3'd0, 16'h0000);
    add_digits(16'h8765, F_LOCKED);
    add(1'b1, 0, K_ENTER, F_OPEN_OK, 3'd0, 16'h0000);
    add(1'b1, 0, K_ENTER, F_LOCKED, 3'd0, 16'h0000);

    for (int i = 0; i < rows.size(); i++) begin
      repeat (rows[i].wait_cyc) @(negedge clk);
      if (rows[i].press) begin
        press(rows[i].key);
        check($sformatf("row%0d key=%h", i, rows[i].key), snap(),
              {rows[i].flags, rows[i].cnt, rows[i].data});
        release_key();
      end else begin
        check($sformatf("row%0d wait=%0d", i, rows[i].wait_cyc), snap(),
              {rows[i].flags, rows[i].cnt, rows[i].data});
      end
    end

    // Held key yields exactly one digit.
    Code_1  = 4'h3;
    Valid_1 = 1'b1;
    repeat (50) @(negedge clk);
    check("held_key", snap(), {F_LOCKED, 3'd1, 16'h0003});
    release_key();
    press_check("fill2", 4'h1, F_LOCKED, 3'd2, 16'h0013);
    press_check("fill3", 4'h1, F_LOCKED, 3'd3, 16'h0113);
    press_check("fill4", 4'h1, F_LOCKED, 3'd4, 16'h1113);
    press_check("overrun_digit", 4'h1, F_LOCKED, 3'd4, 16'h1113);
    press_check("overrun_enter", K_ENTER, F_ERR, 3'd0, 16'h0000);
    // Fail count is now 1: one more wrong stays locked, the next locks out.
    for (int i = 0; i < 4; i++) tap(4'h0);
    press_check("fail2", K_ENTER, F_ERR, 3'd0, 16'h0000);
    for (int i = 0; i < 4; i++) tap(4'h0);
    press_check("fail3_lockout", K_ENTER, F_LO_ERR, 3'd0, 16'h0000);
    for (int i = 0; i < 1100 && LOCKOUT; i++) @(negedge clk);
    check("lockout_exit", snap(), {F_LOCKED, 3'd0, 16'h0000});

    // set_evt and '#' in the same cycle while open: change wins.
    tap(4'h5); tap(4'h6); tap(4'h7); tap(4'h8);
    press_check("open_again", K_ENTER, F_OPEN_OK, 3'd0, 16'h0000);
    set     = 1'b1;
    Code_1  = K_ENTER;
    Valid_1 = 1'b1;
    @(negedge clk);
    check("set_wins", snap(), {F_SET, 3'd0, 16'h0000});
    set     = 1'b0;
    release_key();
    check("no_relock", snap(), {F_SET, 3'd0, 16'h0000});

    // Reset in the middle of confirmation restores the default code.
    tap(4'h1); tap(4'h2); tap(4'h3); tap(4'h4);
    press_check("new2", K_ENTER, F_CHANGE, 3'd0, 16'h0000);
    tap(4'h1); tap(4'h2);
    reset_1 = 1'b0;
    #1;
    check("reset_mid_new2", snap(), {F_LOCKED, 3'd0, 16'h0000});
    @(negedge clk);
    reset_1 = 1'b1;
    @(negedge clk);
    tap(4'h2); tap(4'h4); tap(4'h3); tap(4'h2);
    press_check("default_restored", K_ENTER, F_OPEN_OK, 3'd0, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
